// File: rtl/cp0_regfile_v2_if.sv
// Pipeline <-> CP0 register file connection: MFC0/MTC0, WB exception/ERET commit,
// external interrupt levels, and the EPC/EXL/interrupt-request returns.
interface cp0_regfile_v2_if #(
   parameter int unsigned NUM_HW_INT = 6
);
   logic                  mtc0_wen;
   logic [4:0]            mtc0_addr;
   logic [31:0]           mtc0_wdata;
   logic [4:0]            mfc0_addr;
   logic [31:0]           mfc0_rdata;
   logic                  exc_valid;
   logic [4:0]            exc_code;
   logic [31:0]           exc_pc;
   logic                  exc_bd;
   logic [31:0]           exc_badvaddr;
   logic                  exc_badvaddr_valid;
   logic                  eret;
   logic [NUM_HW_INT-1:0] hw_int;
   logic [31:0]           epc_out;
   logic                  status_exl;
   logic                  int_req;

   modport master (
      output mtc0_wen, mtc0_addr, mtc0_wdata, mfc0_addr,
      output exc_valid, exc_code, exc_pc, exc_bd, exc_badvaddr, exc_badvaddr_valid,
      output eret, hw_int,
      input  mfc0_rdata, epc_out, status_exl, int_req
   );

   modport slave (
      input  mtc0_wen, mtc0_addr, mtc0_wdata, mfc0_addr,
      input  exc_valid, exc_code, exc_pc, exc_bd, exc_badvaddr, exc_badvaddr_valid,
      input  eret, hw_int,
      output mfc0_rdata, epc_out, status_exl, int_req
   );
endinterface

// File: rtl/cp0_regfile_v2.sv
// CP0 system-control register file: BadVAddr/Count/Compare/Status/Cause/EPC,
// prescaled Count with sticky timer interrupt, synchronised HW interrupts,
// BD-corrected EPC held across nested exceptions.
module cp0_regfile_v2 #(
   parameter int unsigned NUM_HW_INT  = 6,
   parameter int unsigned COUNT_DIV   = 2,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic            clk,
   input  logic            rst,
   cp0_regfile_v2_if.slave bus
);
   localparam int unsigned PRESC_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
   localparam int unsigned SYNC_W  = SYNC_STAGES * NUM_HW_INT;
   localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(COUNT_DIV - 1);

   localparam logic [4:0] A_BADVADDR = 5'd8;
   localparam logic [4:0] A_COUNT    = 5'd9;
   localparam logic [4:0] A_COMPARE  = 5'd11;
   localparam logic [4:0] A_STATUS   = 5'd12;
   localparam logic [4:0] A_CAUSE    = 5'd13;
   localparam logic [4:0] A_EPC      = 5'd14;

   logic [31:0]           badvaddr_q, badvaddr_d;
   logic [31:0]           count_q, count_d;
   logic [31:0]           compare_q, compare_d;
   logic [31:0]           epc_q, epc_d;
   logic [7:0]            im_q, im_d;
   logic                  exl_q, exl_d;
   logic                  ie_q, ie_d;
   logic                  bd_q, bd_d;
   logic                  ti_q, ti_d;
   logic [1:0]            ip_sw_q, ip_sw_d;
   logic [4:0]            exccode_q, exccode_d;
   logic [NUM_HW_INT-1:0] hw_ip_q, hw_ip_d;
   logic [PRESC_W-1:0]    presc_q, presc_d;
   logic [SYNC_W-1:0]     sync_q, sync_d;

   logic        mtc0_acc, wr_count, wr_compare, tick;
   logic [31:0] count_inc;
   logic [5:0]  hw_ext;
   logic [7:0]  ip;

   // Cause.IP view: TI shares IP[15] with the sixth HW line; SW bits below.
   always_comb begin
      hw_ext = 6'(hw_ip_q);
      ip     = {ti_q | hw_ext[5], hw_ext[4:0], ip_sw_q};
   end

   // Next-state: timer path runs every cycle, register updates follow exc > eret > mtc0.
   always_comb begin
      badvaddr_d = badvaddr_q;
      count_d    = count_q;
      compare_d  = compare_q;
      epc_d      = epc_q;
      im_d       = im_q;
      exl_d      = exl_q;
      ie_d       = ie_q;
      bd_d       = bd_q;
      ti_d       = ti_q;
      ip_sw_d    = ip_sw_q;
      exccode_d  = exccode_q;
      presc_d    = presc_q;

      mtc0_acc   = bus.mtc0_wen & ~bus.exc_valid & ~bus.eret;
      wr_count   = mtc0_acc && (bus.mtc0_addr == A_COUNT);
      wr_compare = mtc0_acc && (bus.mtc0_addr == A_COMPARE);
      tick       = (presc_q == PRESC_MAX);
      count_inc  = count_q + 32'd1;

      sync_d  = SYNC_W'({sync_q, bus.hw_int});
      hw_ip_d = sync_q[SYNC_W-1 -: NUM_HW_INT];

      if (wr_count) begin
         count_d = bus.mtc0_wdata;
         presc_d = '0;
      end else if (tick) begin
         count_d = count_inc;
         presc_d = '0;
      end else begin
         presc_d = presc_q + PRESC_W'(1);
      end

      if (wr_compare) begin
         compare_d = bus.mtc0_wdata;
         ti_d      = 1'b0;
      end else if (tick && !wr_count && (count_inc == compare_q)) begin
         ti_d = 1'b1;
      end

      if (bus.exc_valid) begin
         if (!exl_q) begin
            epc_d = bus.exc_bd ? (bus.exc_pc - 32'd4) : bus.exc_pc;
            bd_d  = bus.exc_bd;
         end
         exl_d     = 1'b1;
         exccode_d = bus.exc_code;
         if (bus.exc_badvaddr_valid) begin
            badvaddr_d = bus.exc_badvaddr;
         end
      end else if (bus.eret) begin
         exl_d = 1'b0;
      end else if (bus.mtc0_wen) begin
         case (bus.mtc0_addr)
            A_STATUS: begin
               im_d  = bus.mtc0_wdata[15:8];
               exl_d = bus.mtc0_wdata[1];
               ie_d  = bus.mtc0_wdata[0];
            end
            A_CAUSE: ip_sw_d = bus.mtc0_wdata[9:8];
            A_EPC:   epc_d   = bus.mtc0_wdata;
            default: ;
         endcase
      end
   end

   // State registers; async reset restores architectural reset values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         badvaddr_q <= '0;
         count_q    <= '0;
         compare_q  <= '0;
         epc_q      <= '0;
         im_q       <= '0;
         exl_q      <= 1'b0;
         ie_q       <= 1'b0;
         bd_q       <= 1'b0;
         ti_q       <= 1'b0;
         ip_sw_q    <= '0;
         exccode_q  <= '0;
         hw_ip_q    <= '0;
         presc_q    <= '0;
         sync_q     <= '0;
      end else begin
         badvaddr_q <= badvaddr_d;
         count_q    <= count_d;
         compare_q  <= compare_d;
         epc_q      <= epc_d;
         im_q       <= im_d;
         exl_q      <= exl_d;
         ie_q       <= ie_d;
         bd_q       <= bd_d;
         ti_q       <= ti_d;
         ip_sw_q    <= ip_sw_d;
         exccode_q  <= exccode_d;
         hw_ip_q    <= hw_ip_d;
         presc_q    <= presc_d;
         sync_q     <= sync_d;
      end
   end

   // MFC0 read mux from current state, plus the pipeline-facing status outputs.
   always_comb begin
      bus.mfc0_rdata = '0;
      case (bus.mfc0_addr)
         A_BADVADDR: bus.mfc0_rdata = badvaddr_q;
         A_COUNT:    bus.mfc0_rdata = count_q;
         A_COMPARE:  bus.mfc0_rdata = compare_q;
         A_STATUS:   bus.mfc0_rdata = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
         A_CAUSE:    bus.mfc0_rdata = {bd_q, ti_q, 14'b0, ip, 1'b0, exccode_q, 2'b0};
         A_EPC:      bus.mfc0_rdata = epc_q;
         default:    bus.mfc0_rdata = '0;
      endcase
      bus.epc_out    = epc_q;
      bus.status_exl = exl_q;
      bus.int_req    = ie_q & ~exl_q & (|(ip & im_q));
   end
endmodule
